// File: rtl/preg_reclaim.sv
// Reclaim path into the physical-register free list: buffers tags freed at commit,
// in order, and drains them onto the free-list put lanes within its remaining capacity.
module preg_reclaim #(
  parameter  int NUM_PREGS = 64,
  parameter  int TAG_WIDTH = 6,
  parameter  int MAX_IO    = 3,
  parameter  int BUF_DEPTH = 8,
  localparam int LW        = $clog2(NUM_PREGS) + 1,
  localparam int CW        = $clog2(BUF_DEPTH) + 1,
  localparam int PW        = $clog2(BUF_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MAX_IO-1:0]                 free_en_i,
  input  logic [MAX_IO-1:0][TAG_WIDTH-1:0]  free_tag_i,
  output logic                              free_ready_o,
  input  logic [LW-1:0]                     fl_len_i,
  output logic [MAX_IO-1:0]                 put_en_o,
  output logic [MAX_IO-1:0][TAG_WIDTH-1:0]  put_o,
  output logic [CW-1:0]                     buf_count_o,
  output logic                              ovf_err_o,
  output logic                              dbl_free_err_o
);

  logic [BUF_DEPTH-1:0][TAG_WIDTH-1:0] buf_q;
  logic [PW-1:0]                       head_q, tail_q;
  logic [CW-1:0]                       count_q, count_d;
  logic [NUM_PREGS-1:0]                pending_q, pending_d;
  logic                                ovf_q, dbl_q;

  logic                                free_ready;
  logic [LW-1:0]                       space;
  logic [CW-1:0]                       n_out, n_acc;
  logic [MAX_IO-1:0]                   eff;
  logic [MAX_IO-1:0][PW-1:0]           wr_idx;
  logic                                dup, ovf_hit, dbl_hit;

  // Readiness looks only at the registered count; a same-cycle drain earns no credit.
  assign free_ready = (count_q <= CW'(BUF_DEPTH - MAX_IO));

  always_comb begin
    space = (fl_len_i >= LW'(NUM_PREGS)) ? '0 : (LW'(NUM_PREGS) - fl_len_i);
    n_out = (count_q > CW'(MAX_IO)) ? CW'(MAX_IO) : count_q;
    if (space < LW'(n_out)) n_out = CW'(space);
  end

  always_comb begin
    put_en_o = '0;
    put_o    = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      if (CW'(i) < n_out) begin
        put_en_o[i] = 1'b1;
        put_o[i]    = buf_q[head_q + PW'(i)];
      end
    end
  end

  // Lane filtering and prefix-sum compaction of accepted tags.
  always_comb begin
    eff     = '0;
    n_acc   = '0;
    wr_idx  = '0;
    dup     = 1'b0;
    ovf_hit = 1'b0;
    dbl_hit = 1'b0;
    for (int i = 0; i < MAX_IO; i++) begin
      wr_idx[i] = tail_q + PW'(n_acc);
      dup       = pending_q[free_tag_i[i]];
      for (int j = 0; j < i; j++) begin
        if (eff[j] && (free_tag_i[j] == free_tag_i[i])) dup = 1'b1;
      end
      if (free_en_i[i]) begin
        if (!free_ready) begin
          ovf_hit = 1'b1;
        end else if (dup) begin
          dbl_hit = 1'b1;
        end else begin
          eff[i] = 1'b1;
          n_acc  = n_acc + CW'(1);
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < MAX_IO; i++) begin
      if (CW'(i) < n_out) pending_d[buf_q[head_q + PW'(i)]] = 1'b0;
    end
    for (int i = 0; i < MAX_IO; i++) begin
      if (eff[i]) pending_d[free_tag_i[i]] = 1'b1;
    end
    count_d = count_q + n_acc - n_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      dbl_q     <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_IO; i++) begin
        if (eff[i]) buf_q[wr_idx[i]] <= free_tag_i[i];
      end
      head_q    <= head_q + PW'(n_out);
      tail_q    <= tail_q + PW'(n_acc);
      count_q   <= count_d;
      pending_q <= pending_d;
      if (ovf_hit) ovf_q <= 1'b1;
      if (dbl_hit) dbl_q <= 1'b1;
    end
  end

  assign free_ready_o   = free_ready;
  assign buf_count_o    = count_q;
  assign ovf_err_o      = ovf_q;
  assign dbl_free_err_o = dbl_q;

endmodule

// File: tb/tb_preg_reclaim.sv
// Self-checking bench for preg_reclaim: constant vector table, directed corner
// sequences, and a queue scoreboard for the ordered put stream.
module tb_preg_reclaim;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       free_en;
  logic [2:0][5:0]  free_tag;
  logic             free_ready;
  logic [6:0]       fl_len;
  logic [2:0]       put_en;
  logic [2:0][5:0]  put;
  logic [3:0]       buf_count;
  logic             ovf_err, dbl_free_err;

  int total = 0;
  int bad   = 0;

  logic [5:0] sbq[$];
  logic       m_ovf, m_dbl;
  int         popped;

  preg_reclaim dut (
    .clk(clk), .rst(rst),
    .free_en_i(free_en), .free_tag_i(free_tag), .free_ready_o(free_ready),
    .fl_len_i(fl_len), .put_en_o(put_en), .put_o(put),
    .buf_count_o(buf_count), .ovf_err_o(ovf_err), .dbl_free_err_o(dbl_free_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] en;
    logic [5:0] t0, t1, t2;
    logic [6:0] fl;
    logic [2:0] pe;
    logic [5:0] p0, p1, p2;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic [2:0] en, logic [5:0] t0, logic [5:0] t1, logic [5:0] t2,
                              logic [6:0] fl, logic [2:0] pe, logic [5:0] p0, logic [5:0] p1,
                              logic [5:0] p2, logic [3:0] cnt);
    vec_t v;
    v.en = en; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.fl = fl;
    v.pe = pe; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] c, input logic [6:0] fl);
    free_en = en; free_tag[0] = a; free_tag[1] = b; free_tag[2] = c; fl_len = fl;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 0, 0, 0, 7'd64);
    next_cyc();
    rst = 1'b0;
  endtask

  // Scoreboard cycle: predicted drains are popped in accept order, accepts pushed.
  task automatic sb_cycle(input logic [2:0] en, input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] c, input logic [6:0] fl);
    logic [5:0] t[3];
    logic [5:0] acc[$];
    int space, n, qs;
    logic hit;
    drive(en, a, b, c, fl);
    t[0] = a; t[1] = b; t[2] = c;
    @(negedge clk);
    qs    = sbq.size();
    space = (fl >= 7'd64) ? 0 : 64 - int'(fl);
    n     = qs;
    if (n > 3) n = 3;
    if (n > space) n = space;
    chk("sb.put_en", put_en, 32'((1 << n) - 1));
    chk("sb.count", buf_count, qs);
    chk("sb.ready", free_ready, (qs <= 5) ? 1 : 0);
    chk("sb.ovf", ovf_err, m_ovf);
    chk("sb.dbl", dbl_free_err, m_dbl);
    for (int i = 0; i < 3; i++) begin
      if (i < n) chk("sb.put_order", put[i], sbq[i]);
      else       chk("sb.put_idle", put[i], 0);
    end
    for (int i = 0; i < 3; i++) begin
      if (en[i]) begin
        hit = 1'b0;
        foreach (sbq[k]) if (sbq[k] == t[i]) hit = 1'b1;
        foreach (acc[k]) if (acc[k] == t[i]) hit = 1'b1;
        if (qs > 5)   m_ovf = 1'b1;
        else if (hit) m_dbl = 1'b1;
        else          acc.push_back(t[i]);
      end
    end
    for (int i = 0; i < n; i++) void'(sbq.pop_front());
    popped += n;
    foreach (acc[k]) sbq.push_back(acc[k]);
    next_cyc();
  endtask

  vec_t vt[16];

  initial begin
    logic [2:0] pats[8];
    logic [5:0] tg[3];
    int k, p;

    vt[0]  = mk(3'b101,  5,  0,  9,  60, 3'b000,  0,  0,  0, 0);
    vt[1]  = mk(3'b000,  0,  0,  0,  60, 3'b011,  5,  9,  0, 2);
    vt[2]  = mk(3'b000,  0,  0,  0,  60, 3'b000,  0,  0,  0, 0);
    vt[3]  = mk(3'b111,  1,  2,  3,  64, 3'b000,  0,  0,  0, 0);
    vt[4]  = mk(3'b000,  0,  0,  0,  63, 3'b001,  1,  0,  0, 3);
    vt[5]  = mk(3'b000,  0,  0,  0,  64, 3'b000,  0,  0,  0, 2);
    vt[6]  = mk(3'b000,  0,  0,  0,  61, 3'b011,  2,  3,  0, 2);
    vt[7]  = mk(3'b001, 10,  0,  0,  61, 3'b000,  0,  0,  0, 0);
    vt[8]  = mk(3'b000,  0,  0,  0, 100, 3'b000,  0,  0,  0, 1);
    vt[9]  = mk(3'b000,  0,  0,  0,  65, 3'b000,  0,  0,  0, 1);
    vt[10] = mk(3'b010,  0, 33,  0,   0, 3'b001, 10,  0,  0, 1);
    vt[11] = mk(3'b000,  0,  0,  0,   0, 3'b001, 33,  0,  0, 1);
    vt[12] = mk(3'b000,  0,  0,  0,   0, 3'b000,  0,  0,  0, 0);
    vt[13] = mk(3'b111, 63,  0, 62,  64, 3'b000,  0,  0,  0, 0);
    vt[14] = mk(3'b000,  0,  0,  0,   0, 3'b111, 63,  0, 62, 3);
    vt[15] = mk(3'b000,  0,  0,  0,   0, 3'b000,  0,  0,  0, 0);

    rst = 1'b1;
    drive(3'b000, 0, 0, 0, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.put_en", put_en, 0);
    chk("rst.put", put, 0);
    chk("rst.ready", free_ready, 1);
    chk("rst.count", buf_count, 0);
    chk("rst.ovf", ovf_err, 0);
    chk("rst.dbl", dbl_free_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].t0, vt[i].t1, vt[i].t2, vt[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d.put_en", i), put_en, vt[i].pe);
      chk($sformatf("vec%0d.put0", i), put[0], vt[i].p0);
      chk($sformatf("vec%0d.put1", i), put[1], vt[i].p1);
      chk($sformatf("vec%0d.put2", i), put[2], vt[i].p2);
      chk($sformatf("vec%0d.count", i), buf_count, vt[i].cnt);
      chk($sformatf("vec%0d.ready", i), free_ready, 1);
      chk($sformatf("vec%0d.errs", i), {ovf_err, dbl_free_err}, 0);
      next_cyc();
    end

    // Fill with the free list full, then overflow.
    drive(3'b111, 11, 12, 13, 7'd64);
    @(negedge clk); chk("fill.count0", buf_count, 0); chk("fill.ready0", free_ready, 1);
    next_cyc();
    drive(3'b111, 14, 15, 16, 7'd64);
    @(negedge clk); chk("fill.count3", buf_count, 3); chk("fill.ready3", free_ready, 1);
    next_cyc();
    drive(3'b111, 17, 18, 19, 7'd64);
    @(negedge clk); chk("fill.count6", buf_count, 6); chk("fill.ready6", free_ready, 0);
    chk("fill.put_en", put_en, 0);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd63);
    @(negedge clk);
    chk("ovf.flag", ovf_err, 1); chk("ovf.count", buf_count, 6); chk("ovf.dbl", dbl_free_err, 0);
    chk("ovf.put_en", put_en, 3'b001); chk("ovf.put0", put[0], 11);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd64);
    @(negedge clk);
    chk("ovf.count5", buf_count, 5); chk("ovf.ready5", free_ready, 1); chk("ovf.sticky", ovf_err, 1);

    // Asynchronous reset mid-cycle with five tags buffered.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst.count", buf_count, 0); chk("arst.put_en", put_en, 0); chk("arst.put", put, 0);
    chk("arst.ready", free_ready, 1); chk("arst.ovf", ovf_err, 0); chk("arst.dbl", dbl_free_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3'b001, 12, 0, 0, 7'd64);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd64);
    @(negedge clk);
    chk("arst.refree_count", buf_count, 1); chk("arst.refree_dbl", dbl_free_err, 0);
    next_cyc();

    // Duplicate frees: pending tag and same-cycle lower lane.
    do_reset();
    drive(3'b001, 7, 0, 0, 7'd64);
    next_cyc();
    drive(3'b010, 0, 7, 0, 7'd64);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd64);
    @(negedge clk);
    chk("dbl.pending_flag", dbl_free_err, 1); chk("dbl.pending_count", buf_count, 1);
    next_cyc();
    drive(3'b011, 4, 4, 0, 7'd64);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd0);
    @(negedge clk);
    chk("dbl.lane_count", buf_count, 2); chk("dbl.lane_put_en", put_en, 3'b011);
    chk("dbl.lane_put0", put[0], 7); chk("dbl.lane_put1", put[1], 4);
    next_cyc();
    @(negedge clk); chk("dbl.drained", buf_count, 0);
    next_cyc();

    // Re-free of a tag in the very cycle it drains is still a duplicate.
    do_reset();
    drive(3'b001, 20, 0, 0, 7'd0);
    next_cyc();
    drive(3'b001, 20, 0, 0, 7'd0);
    @(negedge clk);
    chk("drfree.put_en", put_en, 3'b001); chk("drfree.put0", put[0], 20); chk("drfree.dbl0", dbl_free_err, 0);
    next_cyc();
    drive(3'b000, 0, 0, 0, 7'd0);
    @(negedge clk);
    chk("drfree.dbl1", dbl_free_err, 1); chk("drfree.count", buf_count, 0); chk("drfree.put_en1", put_en, 0);
    next_cyc();

    // Ordered stream of 20 distinct tags across head wrap.
    do_reset();
    sbq.delete(); m_ovf = 1'b0; m_dbl = 1'b0; popped = 0;
    pats = '{3'b111, 3'b101, 3'b010, 3'b110, 3'b001, 3'b011, 3'b100, 3'b111};
    k = 0; p = 0;
    while (k < 20 && p < 40) begin
      logic [2:0] en;
      en = pats[p % 8];
      for (int i = 0; i < 3; i++) begin
        tg[i] = 6'($urandom_range(0, 63));
        if (en[i]) begin
          if (k < 20) begin tg[i] = 6'(30 + k); k++; end
          else en[i] = 1'b0;
        end
      end
      sb_cycle(en, tg[0], tg[1], tg[2], 7'd50);
      p++;
    end
    for (int c = 0; c < 10; c++) sb_cycle(3'b000, 0, 0, 0, 7'd50);
    chk("stream.total", popped, 20);

    // Random traffic with duplicates and a fluctuating free-list length.
    for (int c = 0; c < 80; c++)
      sb_cycle(3'($urandom_range(0, 7)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
               6'($urandom_range(0, 15)), 7'($urandom_range(55, 66)));
    for (int c = 0; c < 6; c++) sb_cycle(3'b000, 0, 0, 0, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
